// File: rtl/dsp_pkg.sv
// dsp_pkg: shared definitions for the multirate DSP path (decimator_3 / interpolator_3).
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package dsp_pkg;

    localparam int WORD_LENGTH_DEF = 8;
    localparam int LATENCY_DEF     = 4;

    // Counter width able to index every word of a frame; never narrower than 1 bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int CNT_W_DEF = cnt_width(LATENCY_DEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAUSE = 2'd2
    } state_t;

endpackage

// File: rtl/interp_frame_buffer.sv
// interp_frame_buffer: parallel frame register with indexed word read-out.
// Latency: capture visible one clock after i_capture; word select is combinational.
// Backpressure: none; captures unconditionally whenever i_capture is high.
module interp_frame_buffer
    import dsp_pkg::*;
#(
    parameter int word_length = WORD_LENGTH_DEF,
    parameter int latency     = LATENCY_DEF,
    parameter int sel_w       = CNT_W_DEF
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [word_length*latency-1:0]  i_data,
    input  logic                            i_capture,
    input  logic [sel_w-1:0]                i_sel,
    output logic [word_length-1:0]          o_word
);

    logic [latency-1:0][word_length-1:0] r_buf;

    // Frame register: cleared by reset, replaced only on an accepted load.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_buf <= '0;
        end else if (i_capture) begin
            r_buf <= i_data;
        end
    end

    assign o_word = r_buf[i_sel];

endmodule

// File: rtl/interpolator_3.sv
// interpolator_3: parallel-to-serial frame expander, highest word first (build option INTERP_ZERO_STUFF_EN adds a zero after each sample).
// Latency: first sample one clock after the accepted load edge, then one sample per clock.
// Backpressure: hold stalls the stream in place; ready gates load, a rejected load pulses load_ignored.
module interpolator_3
    import dsp_pkg::*;
#(
    parameter int word_length = WORD_LENGTH_DEF,
    parameter int latency     = LATENCY_DEF
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [word_length*latency-1:0]  data_in,
    input  logic                            load,
    input  logic                            hold,
    output logic [word_length-1:0]          data_out,
    output logic                            sample_valid,
    output logic                            ready,
    output logic                            frame_done,
    output logic                            load_ignored
);

    localparam int CW = cnt_width(latency);

    state_t                  r_state, w_state_nxt;
    logic [CW-1:0]           r_count, w_count_nxt, w_sel, w_adv_count;
    logic [word_length-1:0]  r_data_out, w_data_nxt, w_word, w_first, w_adv_data;
    logic                    r_valid, w_valid_nxt;
    logic                    r_done, w_done_nxt;
    logic                    r_ign, w_ign_nxt;
    logic                    w_last, w_ready, w_capture, w_adv_done;
`ifdef INTERP_ZERO_STUFF_EN
    // r_phase=1 while the stuffed zero following word r_count is on the bus.
    logic                    r_phase, w_phase_nxt, w_adv_phase;
`endif

    interp_frame_buffer #(
        .word_length (word_length),
        .latency     (latency),
        .sel_w       (CW)
    ) u_buf (
        .i_clk     (clock),
        .i_rst     (reset),
        .i_data    (data_in),
        .i_capture (w_capture),
        .i_sel     (w_sel),
        .o_word    (w_word)
    );

    // The first word must come straight from data_in: the buffer only holds it after this edge.
    assign w_first = data_in[word_length*latency-1 -: word_length];
    assign w_sel   = r_count - CW'(1);

`ifdef INTERP_ZERO_STUFF_EN
    assign w_last = (r_count == '0) && r_phase;
`else
    assign w_last = (r_count == '0);
`endif

    assign w_ready = (r_state == IDLE) || ((r_state == SHIFT) && w_last && !hold);

    // Values for stepping to the next item of the frame (next word, or the zero after this word).
    always_comb begin
`ifdef INTERP_ZERO_STUFF_EN
        w_adv_phase = ~r_phase;
        if (!r_phase) begin
            w_adv_count = r_count;
            w_adv_data  = '0;
            w_adv_done  = (r_count == '0);
        end else begin
            w_adv_count = w_sel;
            w_adv_data  = w_word;
            w_adv_done  = 1'b0;
        end
`else
        w_adv_count = w_sel;
        w_adv_data  = w_word;
        w_adv_done  = (r_count == CW'(1));
`endif
    end

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_data_nxt  = r_data_out;
        w_valid_nxt = 1'b0;
        w_done_nxt  = 1'b0;
        w_capture   = 1'b0;
        w_ign_nxt   = load && !w_ready;
`ifdef INTERP_ZERO_STUFF_EN
        w_phase_nxt = r_phase;
`endif
        case (r_state)
            IDLE: begin
                // hold has no effect here; a load is always taken and emits its first word.
                if (load) begin
                    w_state_nxt = SHIFT;
                    w_count_nxt = CW'(latency - 1);
                    w_data_nxt  = w_first;
                    w_valid_nxt = 1'b1;
                    w_capture   = 1'b1;
`ifdef INTERP_ZERO_STUFF_EN
                    w_phase_nxt = 1'b0;
`endif
                end else begin
                    w_data_nxt = '0;
                end
            end
            SHIFT: begin
                if (hold) begin
                    w_state_nxt = PAUSE;
                end else if (!w_last) begin
                    w_count_nxt = w_adv_count;
                    w_data_nxt  = w_adv_data;
                    w_valid_nxt = 1'b1;
                    w_done_nxt  = w_adv_done;
`ifdef INTERP_ZERO_STUFF_EN
                    w_phase_nxt = w_adv_phase;
`endif
                end else if (load) begin
                    // Back-to-back frame: new first word follows the last item with no gap.
                    w_count_nxt = CW'(latency - 1);
                    w_data_nxt  = w_first;
                    w_valid_nxt = 1'b1;
                    w_capture   = 1'b1;
`ifdef INTERP_ZERO_STUFF_EN
                    w_phase_nxt = 1'b0;
`endif
                end else begin
                    w_state_nxt = IDLE;
                    w_count_nxt = '0;
                    w_data_nxt  = '0;
`ifdef INTERP_ZERO_STUFF_EN
                    w_phase_nxt = 1'b0;
`endif
                end
            end
            PAUSE: begin
                if (hold) begin
                    w_state_nxt = PAUSE;
                end else if (!w_last) begin
                    w_state_nxt = SHIFT;
                    w_count_nxt = w_adv_count;
                    w_data_nxt  = w_adv_data;
                    w_valid_nxt = 1'b1;
                    w_done_nxt  = w_adv_done;
`ifdef INTERP_ZERO_STUFF_EN
                    w_phase_nxt = w_adv_phase;
`endif
                end else begin
                    // Stalled on the final item: the frame is already complete, so close it out.
                    w_state_nxt = IDLE;
                    w_count_nxt = '0;
                    w_data_nxt  = '0;
`ifdef INTERP_ZERO_STUFF_EN
                    w_phase_nxt = 1'b0;
`endif
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_count_nxt = '0;
                w_data_nxt  = '0;
`ifdef INTERP_ZERO_STUFF_EN
                w_phase_nxt = 1'b0;
`endif
            end
        endcase
    end

    // State, counter and registered outputs; reset overrides everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_data_out <= '0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
            r_ign      <= 1'b0;
`ifdef INTERP_ZERO_STUFF_EN
            r_phase    <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_data_out <= w_data_nxt;
            r_valid    <= w_valid_nxt;
            r_done     <= w_done_nxt;
            r_ign      <= w_ign_nxt;
`ifdef INTERP_ZERO_STUFF_EN
            r_phase    <= w_phase_nxt;
`endif
        end
    end

    assign data_out     = r_data_out;
    assign sample_valid = r_valid;
    assign ready        = w_ready;
    assign frame_done   = r_done;
    assign load_ignored = r_ign;

endmodule

// File: tb/tb_interpolator_3.sv
// tb_interpolator_3: scoreboard bench for interpolator_3 (word_length=8, latency=4).
// Latency: expected samples queued at load time, popped by a negedge monitor.
// Backpressure: hold and overrun loads are driven directly by the stimulus.
module tb_interpolator_3;

    localparam int W = 8;
    localparam int L = 4;
`ifdef INTERP_ZERO_STUFF_EN
    localparam int STEPS     = 2 * L;
    localparam int HOLD_STEP = 3;
`else
    localparam int STEPS     = L;
    localparam int HOLD_STEP = 2;
`endif

    logic           clock = 1'b0;
    logic           reset;
    logic [W*L-1:0] data_in;
    logic           load;
    logic           hold;
    logic [W-1:0]   data_out;
    logic           sample_valid;
    logic           ready;
    logic           frame_done;
    logic           load_ignored;

    int n_checks = 0;
    int n_fail   = 0;

    // Each entry: {frame_done, data_out} expected on the next valid cycle.
    logic [W:0] exp_q[$];

    interpolator_3 #(.word_length(W), .latency(L)) dut (
        .clock        (clock),
        .reset        (reset),
        .data_in      (data_in),
        .load         (load),
        .hold         (hold),
        .data_out     (data_out),
        .sample_valid (sample_valid),
        .ready        (ready),
        .frame_done   (frame_done),
        .load_ignored (load_ignored)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_ready(input logic exp);
        #1;
        check("ready", {31'd0, ready}, {31'd0, exp});
    endtask

    // Monitor: every valid cycle must match the head of the expected stream.
    initial begin
        logic [W:0] e;
        forever begin
            @(negedge clock);
            if (sample_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_sample: got 0x%0h with nothing expected at %0t", data_out, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("sample_data", {24'd0, data_out}, {24'd0, e[W-1:0]});
                    check("frame_done", {31'd0, frame_done}, {31'd0, e[W]});
                end
            end else begin
                check("done_without_valid", {31'd0, frame_done}, 32'd0);
            end
        end
    end

    // One frame from the load edge to its last item; leaves the last item on the bus, hold low.
    task automatic send_frame(input logic [W*L-1:0] d, input bit hs, input int hold_step,
                              input int hold_len, input int max_hold, input int ov_step,
                              input bit rand_ov);
        logic [W-1:0] seq[STEPS];
        logic [W-1:0] w;
        logic         lastw;
        int           idx;
        idx = 0;
        for (int k = L - 1; k >= 0; k--) begin
            w     = d[k*W +: W];
            lastw = (k == 0);
`ifdef INTERP_ZERO_STUFF_EN
            seq[idx] = w;
            exp_q.push_back({1'b0, w});
            idx++;
            seq[idx] = '0;
            exp_q.push_back({lastw, 8'h00});
            idx++;
`else
            seq[idx] = w;
            exp_q.push_back({lastw, w});
            idx++;
`endif
        end
        hold    = hs;
        load    = 1'b1;
        data_in = d;
        check_ready(1'b1);
        tick();
        load    = 1'b0;
        data_in = $urandom;
        for (int s = 1; s < STEPS; s++) begin
            int nh;
            bit ov;
            if (s == hold_step) nh = hold_len;
            else if (max_hold > 0) nh = $urandom_range(max_hold, 0);
            else nh = 0;
            if (s == 1 && hs && nh == 0) nh = 1;
            for (int h = 0; h < nh; h++) begin
                hold = 1'b1;
                check_ready(1'b0);
                tick();
                check("hold_valid", {31'd0, sample_valid}, 32'd0);
                check("hold_data", {24'd0, data_out}, {24'd0, seq[s-1]});
                check("hold_no_ignore", {31'd0, load_ignored}, 32'd0);
            end
            ov      = (s == ov_step) || (rand_ov && ($urandom_range(3, 0) == 0));
            hold    = 1'b0;
            load    = ov;
            data_in = $urandom;
            check_ready(1'b0);
            tick();
            load = 1'b0;
            check("load_ignored", {31'd0, load_ignored}, {31'd0, ov});
        end
        check_ready(1'b1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            load = 1'b0;
            hold = (i == 0) ? 1'b0 : 1'($urandom_range(1, 0));
            check_ready(1'b1);
            tick();
            check("idle_valid", {31'd0, sample_valid}, 32'd0);
            check("idle_data", {24'd0, data_out}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit from_idle;
        reset   = 1'b1;
        load    = 1'b0;
        hold    = 1'b0;
        data_in = '0;
        tick();
        // Reset must win over a simultaneous load.
        load    = 1'b1;
        data_in = 32'hDEADBEEF;
        tick();
        load = 1'b0;
        check("rst_data", {24'd0, data_out}, 32'd0);
        check("rst_valid", {31'd0, sample_valid}, 32'd0);
        check("rst_done", {31'd0, frame_done}, 32'd0);
        check("rst_ignored", {31'd0, load_ignored}, 32'd0);
        check_ready(1'b1);
        reset = 1'b0;

        // Single frame, then return to idle.
        send_frame(32'hA1B2C3D4, 1'b0, -1, 0, 0, -1, 1'b0);
        idle_cycles(2);

        // Back-to-back frames with no bubble.
        send_frame(32'h01020304, 1'b0, -1, 0, 0, -1, 1'b0);
        send_frame(32'h05060708, 1'b0, -1, 0, 0, -1, 1'b0);
        idle_cycles(1);

        // Hold for 3 cycles after the 22 sample.
        send_frame(32'h11223344, 1'b0, HOLD_STEP, 3, 0, -1, 1'b0);
        idle_cycles(1);

        // Overrun load during the second sample.
        send_frame(32'hC0FFEE42, 1'b0, -1, 0, 0, 2, 1'b0);
        idle_cycles(1);

        // Reset after two samples, then a clean restart.
`ifdef INTERP_ZERO_STUFF_EN
        exp_q.push_back({1'b0, 8'h55});
        exp_q.push_back({1'b0, 8'h00});
`else
        exp_q.push_back({1'b0, 8'h55});
        exp_q.push_back({1'b0, 8'h66});
`endif
        data_in = 32'h55667788;
        load    = 1'b1;
        tick();
        load    = 1'b0;
        data_in = $urandom;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        check("midrst_data", {24'd0, data_out}, 32'd0);
        check("midrst_valid", {31'd0, sample_valid}, 32'd0);
        check("midrst_done", {31'd0, frame_done}, 32'd0);
        check("midrst_ignored", {31'd0, load_ignored}, 32'd0);
        check_ready(1'b1);
        send_frame(32'h99AABBCC, 1'b0, -1, 0, 0, -1, 1'b0);
        idle_cycles(1);

        // Randomized frames: random holds, overruns, gaps and back-to-back reloads.
        from_idle = 1'b1;
        for (int f = 0; f < 40; f++) begin
            send_frame($urandom, from_idle && ($urandom_range(2, 0) == 0), -1, 0, 3, -1, 1'b1);
            if ($urandom_range(1, 0) == 1) begin
                idle_cycles($urandom_range(3, 1));
                from_idle = 1'b1;
            end else begin
                from_idle = 1'b0;
            end
        end
        idle_cycles(3);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
